// File: rtl/index_sequencer_if.sv
// Command and register-file bus of index_sequencer. The sequencer attaches
// through the slave modport; the requester plus the 16x4 file use master.
interface index_sequencer_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 4
);
    // Handshake: REQ is sampled only on an edge where BUSY=0; a REQ seen while
    // BUSY=1 is dropped, not queued. DONE pulses one cycle when the write has
    // committed, and RESULT/CARRY hold that command's outcome until the next DONE.
    logic              REQ;
    logic [1:0]        OP;
    logic [ADDR_W-1:0] IDX;
    logic [DATA_W-1:0] IMM;
    logic              BUSY;
    logic              DONE;
    logic [DATA_W-1:0] RESULT;
    logic              CARRY;
    logic [ADDR_W-1:0] RF_R_ADDR;
    logic [DATA_W-1:0] RF_R_DATA;
    logic              RF_S;
    logic [ADDR_W-1:0] RF_W_ADDR;
    logic [DATA_W-1:0] RF_W_DATA;

    modport slave (
        input  REQ, OP, IDX, IMM, RF_R_DATA,
        output BUSY, DONE, RESULT, CARRY, RF_R_ADDR, RF_S, RF_W_ADDR, RF_W_DATA
    );

    modport master (
        output REQ, OP, IDX, IMM, RF_R_DATA,
        input  BUSY, DONE, RESULT, CARRY, RF_R_ADDR, RF_S, RF_W_ADDR, RF_W_DATA
    );
endinterface

// File: rtl/index_sequencer.sv
// Read-modify-write sequencer for the 16x4 index register file (LOAD/INC/DEC/ADD).
// Define INDEX_SEQ_SAT_EN for saturating arithmetic instead of modulo-16 wrap.
module index_sequencer #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 4
) (
    input  logic              CLK,
    input  logic              RST_N,
    index_sequencer_if.slave  bus,
    output logic [1:0]        dbg_state
);
    localparam logic [1:0] OP_LOAD = 2'b00;
    localparam logic [1:0] OP_INC  = 2'b01;
    localparam logic [1:0] OP_DEC  = 2'b10;
    localparam logic [1:0] OP_ADD  = 2'b11;
    localparam logic [DATA_W:0] ONE = {{DATA_W{1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2
    } state_t;

    state_t            state;
    logic [1:0]        op_q;
    logic [ADDR_W-1:0] idx_q;
    logic [DATA_W-1:0] imm_q;
    logic [ADDR_W-1:0] w_addr_q;
    logic [DATA_W-1:0] w_data_q;
    logic              pend_carry_q;
    logic              done_q;
    logic [DATA_W-1:0] result_q;
    logic              carry_q;

    logic [DATA_W:0]   sum;
    logic [DATA_W-1:0] nxt_val;
    logic              nxt_carry;

    // Bit DATA_W of the widened sum is the carry for INC/ADD and the borrow for DEC.
    always_comb begin
        sum = {1'b0, imm_q};
        case (op_q)
            OP_INC:  sum = {1'b0, bus.RF_R_DATA} + ONE;
            OP_DEC:  sum = {1'b0, bus.RF_R_DATA} - ONE;
            OP_ADD:  sum = {1'b0, bus.RF_R_DATA} + {1'b0, imm_q};
            default: sum = {1'b0, imm_q};
        endcase
        nxt_carry = sum[DATA_W] & (op_q != OP_LOAD);
        nxt_val   = sum[DATA_W-1:0];
`ifdef INDEX_SEQ_SAT_EN
        if (nxt_carry) begin
            nxt_val = (op_q == OP_DEC) ? '0 : '1;
        end
`endif
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state        <= IDLE;
            op_q         <= '0;
            idx_q        <= '0;
            imm_q        <= '0;
            w_addr_q     <= '0;
            w_data_q     <= '0;
            pend_carry_q <= 1'b0;
            done_q       <= 1'b0;
            result_q     <= '0;
            carry_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.REQ) begin
                        op_q  <= bus.OP;
                        idx_q <= bus.IDX;
                        imm_q <= bus.IMM;
                        // LOAD needs no operand, so it bypasses the read cycle.
                        if (bus.OP == OP_LOAD) begin
                            w_addr_q     <= bus.IDX;
                            w_data_q     <= bus.IMM;
                            pend_carry_q <= 1'b0;
                            state        <= WRITE;
                        end else begin
                            state <= READ;
                        end
                    end
                end
                READ: begin
                    w_addr_q     <= idx_q;
                    w_data_q     <= nxt_val;
                    pend_carry_q <= nxt_carry;
                    state        <= WRITE;
                end
                WRITE: begin
                    done_q   <= 1'b1;
                    result_q <= w_data_q;
                    carry_q  <= pend_carry_q;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Gating with RST_N keeps a reset asserted during WRITE from corrupting the file.
    assign bus.RF_S      = (state == WRITE) & RST_N;
    assign bus.RF_R_ADDR = idx_q;
    assign bus.RF_W_ADDR = w_addr_q;
    assign bus.RF_W_DATA = w_data_q;
    assign bus.BUSY      = (state != IDLE);
    assign bus.DONE      = done_q;
    assign bus.RESULT    = result_q;
    assign bus.CARRY     = carry_q;
    assign dbg_state     = state;
endmodule

// File: tb/tb_index_sequencer.sv
// Bench for index_sequencer: directed vector table, hold/reset sequences and
// random commands checked against an integer reference model of the file.
module tb_index_sequencer;
    localparam logic [1:0] OP_LOAD = 2'b00;
    localparam logic [1:0] OP_INC  = 2'b01;
    localparam logic [1:0] OP_DEC  = 2'b10;
    localparam logic [1:0] OP_ADD  = 2'b11;
`ifdef INDEX_SEQ_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic       CLK = 1'b0;
    logic       RST_N = 1'b0;
    logic [1:0] dbg_state;
    int         n_cmp = 0;
    int         n_fail = 0;
    int         wr_cnt = 0;
    logic [3:0] rf_mem [16] = '{default: 4'd0};
    logic [3:0] exp_q [$];
    int         model [16];

    index_sequencer_if #(.ADDR_W(4), .DATA_W(4)) bus ();

    index_sequencer #(.ADDR_W(4), .DATA_W(4)) dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    // clock / reset
    always #5 CLK = ~CLK;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // register file: combinational read, write on rising edge when RF_S
    assign bus.RF_R_DATA = rf_mem[bus.RF_R_ADDR];
    always @(posedge CLK) begin
        if (bus.RF_S) begin
            rf_mem[bus.RF_W_ADDR] <= bus.RF_W_DATA;
            wr_cnt <= wr_cnt + 1;
        end
    end

    task automatic check(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // scoreboard: every DONE must match the oldest expected result
    always @(negedge CLK) begin
        if (bus.DONE) begin
            if (exp_q.size() == 0) check("unexpected_done", 1, 0);
            else check("result", int'(bus.RESULT), int'(exp_q.pop_front()));
        end
    end

    // reference: plain integer arithmetic on the operand
    task automatic ref_op(input int op, input int v, input int imm, output int res, output int cy);
        int s;
        case (op)
            0:       s = imm;
            1:       s = v + 1;
            2:       s = v - 1;
            default: s = v + imm;
        endcase
        cy = (op != 0 && (s > 15 || s < 0)) ? 1 : 0;
        if (SAT) res = (s > 15) ? 15 : (s < 0) ? 0 : s;
        else     res = (s + 16) % 16;
    endtask

    // driver: call just after a rising edge with the sequencer idle
    task automatic do_cmd(input logic [1:0] op, input logic [3:0] idx, input logic [3:0] imm,
                          input logic [3:0] exp_res, input logic exp_cy, input int exp_lat);
        int lat;
        int w0;
        exp_q.push_back(exp_res);
        w0 = wr_cnt;
        bus.REQ = 1'b1; bus.OP = op; bus.IDX = idx; bus.IMM = imm;
        @(posedge CLK); #1;
        bus.REQ = 1'b0;
        bus.OP  = 2'($urandom_range(0, 3));
        bus.IDX = 4'($urandom_range(0, 15));
        bus.IMM = 4'($urandom_range(0, 15));
        check("busy_after_accept", int'(bus.BUSY), 1);
        lat = 0;
        while (!bus.DONE && lat < 8) begin
            @(posedge CLK); #1;
            lat++;
        end
        check("done_latency", lat, exp_lat);
        check("carry", int'(bus.CARRY), int'(exp_cy));
        check("busy_at_done", int'(bus.BUSY), 0);
        check("write_count", wr_cnt - w0, 1);
        check("rf_value", int'(rf_mem[idx]), int'(exp_res));
    endtask

    typedef struct {
        logic [1:0] op;
        logic [3:0] idx;
        logic [3:0] imm;
        logic [3:0] pre;
        logic [3:0] res;
        logic       cy;
        int         lat;
    } vec_t;

    vec_t vecs [10];

    initial begin
        int w0;
        int r;
        int c;
        logic [1:0] op;
        logic [3:0] idx;
        logic [3:0] imm;

        vecs[0] = '{OP_LOAD, 4'd3,  4'd9,  4'd0,  4'd9,                   1'b0, 1};
        vecs[1] = '{OP_INC,  4'd3,  4'd0,  4'd15, SAT ? 4'd15 : 4'd0,     1'b1, 2};
        vecs[2] = '{OP_DEC,  4'd5,  4'd0,  4'd0,  SAT ? 4'd0 : 4'd15,     1'b1, 2};
        vecs[3] = '{OP_ADD,  4'd7,  4'd6,  4'd12, SAT ? 4'd15 : 4'd2,     1'b1, 2};
        vecs[4] = '{OP_ADD,  4'd7,  4'd3,  4'd2,  4'd5,                   1'b0, 2};
        vecs[5] = '{OP_INC,  4'd1,  4'd0,  4'd4,  4'd5,                   1'b0, 2};
        vecs[6] = '{OP_DEC,  4'd9,  4'd0,  4'd8,  4'd7,                   1'b0, 2};
        vecs[7] = '{OP_ADD,  4'd15, 4'd15, 4'd15, SAT ? 4'd15 : 4'd14,    1'b1, 2};
        vecs[8] = '{OP_ADD,  4'd0,  4'd0,  4'd0,  4'd0,                   1'b0, 2};
        vecs[9] = '{OP_INC,  4'd2,  4'd0,  4'd14, 4'd15,                  1'b0, 2};

        bus.REQ = 1'b0; bus.OP = 2'd0; bus.IDX = 4'd0; bus.IMM = 4'd0;
        RST_N = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        check("rst_busy", int'(bus.BUSY), 0);
        check("rst_done", int'(bus.DONE), 0);
        check("rst_result", int'(bus.RESULT), 0);
        check("rst_carry", int'(bus.CARRY), 0);
        check("rst_rf_s", int'(bus.RF_S), 0);
        check("rst_r_addr", int'(bus.RF_R_ADDR), 0);
        check("rst_w_addr", int'(bus.RF_W_ADDR), 0);
        check("rst_w_data", int'(bus.RF_W_DATA), 0);
        check("rst_state", int'(dbg_state), 0);
        RST_N = 1'b1;
        @(posedge CLK); #1;

        // directed table
        for (int i = 0; i < 10; i++) begin
            if (vecs[i].op != OP_LOAD)
                do_cmd(OP_LOAD, vecs[i].idx, vecs[i].pre, vecs[i].pre, 1'b0, 1);
            do_cmd(vecs[i].op, vecs[i].idx, vecs[i].imm, vecs[i].res, vecs[i].cy, vecs[i].lat);
        end

        // REQ held through a command with changing fields, then accepted in DONE cycle
        do_cmd(OP_LOAD, 4'd4, 4'd4, 4'd4, 1'b0, 1);
        do_cmd(OP_LOAD, 4'd6, 4'd11, 4'd11, 1'b0, 1);
        exp_q.push_back(4'd5);
        exp_q.push_back(4'd6);
        w0 = wr_cnt;
        bus.REQ = 1'b1; bus.OP = OP_INC; bus.IDX = 4'd4; bus.IMM = 4'd0;
        @(posedge CLK); #1;
        bus.OP = OP_LOAD; bus.IDX = 4'd6; bus.IMM = 4'd2;
        @(posedge CLK); #1;
        check("hold_busy", int'(bus.BUSY), 1);
        bus.OP = OP_INC; bus.IDX = 4'd4; bus.IMM = 4'd0;
        @(posedge CLK); #1;
        check("hold_done1", int'(bus.DONE), 1);
        check("hold_rf4_first", int'(rf_mem[4]), 5);
        @(posedge CLK); #1;
        bus.REQ = 1'b0;
        check("hold_second_busy", int'(bus.BUSY), 1);
        check("hold_second_done_low", int'(bus.DONE), 0);
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        check("hold_done2", int'(bus.DONE), 1);
        check("hold_rf4_second", int'(rf_mem[4]), 6);
        check("hold_rf6_untouched", int'(rf_mem[6]), 11);
        check("hold_write_count", wr_cnt - w0, 2);

        // reset asserted during the WRITE cycle of an ADD
        do_cmd(OP_LOAD, 4'd7, 4'd2, 4'd2, 1'b0, 1);
        w0 = wr_cnt;
        bus.REQ = 1'b1; bus.OP = OP_ADD; bus.IDX = 4'd7; bus.IMM = 4'd3;
        @(posedge CLK); #1;
        bus.REQ = 1'b0;
        @(posedge CLK); #1;
        check("abort_in_write", int'(dbg_state), 2);
        check("abort_rf_s_before", int'(bus.RF_S), 1);
        RST_N = 1'b0;
        #1;
        check("abort_rf_s_gated", int'(bus.RF_S), 0);
        @(posedge CLK); #1;
        check("abort_busy", int'(bus.BUSY), 0);
        check("abort_done", int'(bus.DONE), 0);
        check("abort_result", int'(bus.RESULT), 0);
        check("abort_carry", int'(bus.CARRY), 0);
        check("abort_r_addr", int'(bus.RF_R_ADDR), 0);
        check("abort_w_addr", int'(bus.RF_W_ADDR), 0);
        check("abort_w_data", int'(bus.RF_W_DATA), 0);
        check("abort_state", int'(dbg_state), 0);
        check("abort_rf7", int'(rf_mem[7]), 2);
        check("abort_writes", wr_cnt - w0, 0);
        RST_N = 1'b1;
        @(posedge CLK); #1;
        check("abort_no_late_done", int'(bus.DONE), 0);

        // random commands against the model
        for (int i = 0; i < 16; i++) begin
            model[i] = $urandom_range(0, 15);
            do_cmd(OP_LOAD, 4'(i), 4'(model[i]), 4'(model[i]), 1'b0, 1);
        end
        for (int n = 0; n < 300; n++) begin
            op  = 2'($urandom_range(0, 3));
            idx = 4'($urandom_range(0, 15));
            imm = 4'($urandom_range(0, 15));
            ref_op(int'(op), model[idx], int'(imm), r, c);
            model[idx] = r;
            do_cmd(op, idx, imm, 4'(r), c[0], (op == OP_LOAD) ? 1 : 2);
            repeat ($urandom_range(0, 2)) begin
                @(posedge CLK); #1;
            end
        end

        @(posedge CLK); #1;
        check("queue_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
